// File: rtl/ss_pkg.sv
// ss_pkg: shared types and constants for the save-state initiator.
// FSM state enum, header word layout and a header packing helper.
package ss_pkg;

  localparam int SS_DATA_W      = 64;
  localparam int SS_HDR_IDX_LSB = 56;
  localparam int SS_HDR_CNT_W   = 16;

  typedef enum logic [3:0] {
    IDLE,
    QUERY,
    HDR,
    SLV_RD,
    MEM_WR,
    MEM_RD,
    SLV_WR,
    NEXT,
    DONE
  } ss_state_t;

  // Header word: {idx[7:0], 40'b0, count[15:0]}
  function automatic logic [SS_DATA_W-1:0] ss_hdr(
    input logic [7:0]              idx,
    input logic [SS_HDR_CNT_W-1:0] cnt
  );
    logic [SS_DATA_W-1:0] w;
    w = '0;
    w[SS_HDR_IDX_LSB +: 8]  = idx;
    w[SS_HDR_CNT_W-1:0]     = cnt;
    return w;
  endfunction

endpackage

// File: rtl/ss_state_master_if.sv
// ss_state_master_if: save-state slave bus plus 64-bit memory port.
// master = initiator side, slave = chip models and memory side.
interface ss_state_master_if
  import ss_pkg::*;
#(
  parameter int ADDR_W = 24
);

  logic [7:0]           ss_idx;
  logic [7:0]           ss_addr;
  logic [SS_DATA_W-1:0] ss_wdata;
  logic                 ss_query;
  logic                 ss_read;
  logic                 ss_write;
  logic                 ss_ack;
  logic [SS_DATA_W-1:0] ss_rdata;

  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [SS_DATA_W-1:0] mem_wdata;
  logic                 mem_ack;
  logic [SS_DATA_W-1:0] mem_rdata;

  modport master (
    output ss_idx, ss_addr, ss_wdata,
    output ss_query, ss_read, ss_write,
    input  ss_ack, ss_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  ss_idx, ss_addr, ss_wdata,
    input  ss_query, ss_read, ss_write,
    output ss_ack, ss_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/ss_timeout.sv
// ss_timeout: loadable down-counter for slave ack waits.
// Ports: clk, reset, load (reload), run (request active), expire.
module ss_timeout #(
  parameter  int TIMEOUT = 255,
  localparam int W       = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expire
);

  // Request cycle k sees TIMEOUT-k, so the TIMEOUT-th
  // unacked cycle is the one that expires.
  localparam logic [W-1:0] RELOAD = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (run && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = run && (cnt == '0);

endmodule

// File: rtl/ss_state_master.sv
// ss_state_master: save-state bus initiator; saves slaves to memory
// or restores them. Ports: clk, reset, start_*, base_addr, busy,
// done, error, bus (slave + memory handshakes).
module ss_state_master
  import ss_pkg::*;
#(
  parameter int NUM_IDX = 32,
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_save,
  input  logic              start_restore,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              error,
  ss_state_master_if.master bus
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_IDX - 1);

  ss_state_t state, state_d;
  logic      gap, gap_d;

  logic                    save_mode;
  logic [7:0]              idx;
  logic [SS_HDR_CNT_W-1:0] cnt;
  logic [SS_HDR_CNT_W-1:0] reg_i;
  logic [ADDR_W-1:0]       ptr;
  logic [SS_DATA_W-1:0]    ss_wdata_q;
  logic [SS_DATA_W-1:0]    mem_wdata_q;
  logic                    error_q;

  logic query_o, read_o, write_o, mreq_o;
  logic start, ss_act, ss_hit, mem_hit;
  logic expire, tmo, last_reg, hdr_ok;
  logic [SS_HDR_CNT_W-1:0] q_cnt;

  assign start    = start_save | start_restore;
  assign ss_act   = query_o | read_o | write_o;
  assign ss_hit   = ss_act & bus.ss_ack;
  assign mem_hit  = mreq_o & bus.mem_ack;
  assign tmo      = expire & ~bus.ss_ack;
  assign last_reg = (reg_i + 16'd1) == cnt;
  assign q_cnt    = ss_hit ? bus.ss_rdata[SS_HDR_CNT_W-1:0]
                           : '0;
  assign hdr_ok   =
    (bus.mem_rdata[SS_HDR_IDX_LSB +: 8] == idx) &&
    (bus.mem_rdata[SS_HDR_CNT_W-1:0] == cnt);

  ss_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .load   (~ss_act),
    .run    (ss_act),
    .expire (expire)
  );

  // gap suppresses the strobe for the one cycle after an ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gap   <= 1'b0;
    end else begin
      state <= state_d;
      gap   <= gap_d;
    end
  end

  always_comb begin
    state_d = state;
    gap_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_d = QUERY;
      end
      QUERY: begin
        if (ss_hit || tmo) begin
          state_d = HDR;
          gap_d   = 1'b1;
        end
      end
      HDR: begin
        if (mem_hit) begin
          gap_d = 1'b1;
          if (!save_mode && !hdr_ok)
            state_d = DONE;
          else if (cnt == '0)
            state_d = NEXT;
          else
            state_d = save_mode ? SLV_RD : MEM_RD;
        end
      end
      SLV_RD: begin
        if (ss_hit) begin
          state_d = MEM_WR;
          gap_d   = 1'b1;
        end else if (tmo) begin
          state_d = DONE;
        end
      end
      MEM_WR: begin
        if (mem_hit) begin
          state_d = last_reg ? NEXT : SLV_RD;
          gap_d   = 1'b1;
        end
      end
      MEM_RD: begin
        if (mem_hit) begin
          state_d = SLV_WR;
          gap_d   = 1'b1;
        end
      end
      SLV_WR: begin
        if (ss_hit) begin
          state_d = last_reg ? NEXT : MEM_RD;
          gap_d   = 1'b1;
        end else if (tmo) begin
          state_d = DONE;
        end
      end
      NEXT: begin
        state_d = (idx == LAST_IDX) ? DONE : QUERY;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    query_o = 1'b0;
    read_o  = 1'b0;
    write_o = 1'b0;
    mreq_o  = 1'b0;
    unique case (state)
      QUERY:               query_o = ~gap;
      SLV_RD:              read_o  = ~gap;
      SLV_WR:              write_o = ~gap;
      HDR, MEM_WR, MEM_RD: mreq_o  = ~gap;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      save_mode   <= 1'b0;
      idx         <= '0;
      cnt         <= '0;
      reg_i       <= '0;
      ptr         <= '0;
      ss_wdata_q  <= '0;
      mem_wdata_q <= '0;
      error_q     <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        save_mode <= start_save;
        idx       <= '0;
        reg_i     <= '0;
        ptr       <= base_addr;
        error_q   <= 1'b0;
      end
      // header word is staged as soon as the count is known
      if (state == QUERY && (ss_hit || tmo)) begin
        cnt         <= q_cnt;
        mem_wdata_q <= ss_hdr(idx, q_cnt);
      end
      if (mem_hit)
        ptr <= ptr + 1'b1;
      if (state == HDR && mem_hit && !save_mode && !hdr_ok)
        error_q <= 1'b1;
      if ((state == SLV_RD || state == SLV_WR) && tmo)
        error_q <= 1'b1;
      if (state == SLV_RD && ss_hit)
        mem_wdata_q <= bus.ss_rdata;
      if (state == MEM_RD && mem_hit)
        ss_wdata_q <= bus.mem_rdata;
      if (((state == MEM_WR && mem_hit) ||
           (state == SLV_WR && ss_hit)) && !last_reg)
        reg_i <= reg_i + 16'd1;
      if (state == NEXT) begin
        reg_i <= '0;
        if (idx != LAST_IDX)
          idx <= idx + 8'd1;
      end
    end
  end

  assign busy  = (state != IDLE) && (state != DONE);
  assign done  = (state == DONE) && !error_q;
  assign error = error_q;

  assign bus.ss_idx    = idx;
  assign bus.ss_addr   = reg_i[7:0];
  assign bus.ss_wdata  = ss_wdata_q;
  assign bus.ss_query  = query_o;
  assign bus.ss_read   = read_o;
  assign bus.ss_write  = write_o;
  assign bus.mem_req   = mreq_o;
  assign bus.mem_we    = mreq_o & save_mode;
  assign bus.mem_addr  = ptr;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ss_state_master.sv
// tb_ss_state_master: directed save/restore scenarios with a
// transaction-level expectation queue and bus responders.
module tb_ss_state_master;

  localparam int NIDX = 2;
  localparam int K_Q  = 0;
  localparam int K_RD = 1;
  localparam int K_WR = 2;
  localparam int K_MW = 3;
  localparam int K_MR = 4;

  typedef struct {
    int          kind;
    int          idx;
    int          addr;
    logic [63:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_save, start_restore;
  logic [23:0] base_addr;
  logic        busy, done, error;

  ss_state_master_if #(.ADDR_W(24)) bus ();

  ss_state_master #(
    .NUM_IDX (NIDX),
    .ADDR_W  (24),
    .TIMEOUT (255)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_save    (start_save),
    .start_restore (start_restore),
    .base_addr     (base_addr),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ndone = 0;
  int nwr   = 0;
  bit chk_en = 1'b0;
  bit exp_err;
  txn_t expq[$];

  bit          present[NIDX];
  int          scnt[NIDX];
  logic [63:0] sregs[NIDX][4];
  logic [63:0] swr[NIDX][4];
  logic [63:0] img[int unsigned];
  logic [63:0] mem[int unsigned];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void push(input int k, input int i,
                               input int a, input logic [63:0] d);
    txn_t t;
    t.kind = k; t.idx = i; t.addr = a; t.data = d;
    expq.push_back(t);
  endfunction

  function automatic logic [63:0] hdr_of(input int i, input int c);
    return (64'(i) << 56) | 64'(c);
  endfunction

  function automatic logic [63:0] rd_img(input logic [23:0] a);
    return img.exists(int'(a)) ? img[int'(a)] : 64'h0;
  endfunction

  function automatic void model_save(input logic [23:0] base);
    logic [23:0] a;
    int c;
    a = base;
    for (int i = 0; i < NIDX; i++) begin
      c = present[i] ? scnt[i] : 0;
      if (present[i]) push(K_Q, i, 0, 0);
      push(K_MW, 0, int'(a), hdr_of(i, c));
      a++;
      for (int r = 0; r < c; r++) begin
        push(K_RD, i, r, 0);
        push(K_MW, 0, int'(a), sregs[i][r]);
        a++;
      end
    end
    exp_err = 1'b0;
  endfunction

  function automatic void model_restore(input logic [23:0] base);
    logic [23:0] a;
    logic [63:0] h;
    int c;
    a = base;
    exp_err = 1'b0;
    for (int i = 0; i < NIDX; i++) begin
      c = present[i] ? scnt[i] : 0;
      if (present[i]) push(K_Q, i, 0, 0);
      push(K_MR, 0, int'(a), 0);
      h = rd_img(a);
      a++;
      if (h[63:56] != 8'(i) || h[15:0] != 16'(c)) begin
        exp_err = 1'b1;
        return;
      end
      for (int r = 0; r < c; r++) begin
        push(K_MR, 0, int'(a), 0);
        push(K_WR, i, r, rd_img(a));
        a++;
      end
    end
  endfunction

  task automatic slave_resp();
    int w = 0;
    int n = 0;
    int i;
    forever begin
      @(negedge clk);
      i = int'(bus.ss_idx[0]);
      if (bus.ss_query || bus.ss_read || bus.ss_write) begin
        if (present[i] && w >= n % 3) begin
          bus.ss_ack = 1'b1;
          if (bus.ss_query)
            bus.ss_rdata = 64'(scnt[i]);
          else if (bus.ss_read)
            bus.ss_rdata = sregs[i][bus.ss_addr[1:0]];
          else begin
            swr[i][bus.ss_addr[1:0]] = bus.ss_wdata;
            nwr++;
          end
          w = 0;
          n++;
        end else begin
          bus.ss_ack = 1'b0;
          w++;
        end
      end else begin
        bus.ss_ack = 1'b0;
        w = 0;
      end
    end
  endtask

  task automatic mem_resp();
    int w = 0;
    int n = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_req && w >= n % 2) begin
        bus.mem_ack = 1'b1;
        if (bus.mem_we)
          mem[int'(bus.mem_addr)] = bus.mem_wdata;
        else
          bus.mem_rdata = rd_img(bus.mem_addr);
        w = 0;
        n++;
      end else begin
        bus.mem_ack = 1'b0;
        w = bus.mem_req ? w + 1 : 0;
      end
    end
  endtask

  task automatic monitor();
    txn_t t;
    int k;
    int ns;
    forever begin
      @(negedge clk);
      #1;
      if (chk_en && !reset) begin
        ns = int'(bus.ss_query) + int'(bus.ss_read) +
             int'(bus.ss_write) + int'(bus.mem_req);
        chk("one_strobe", 64'(ns <= 1), 64'd1);
        if (done) begin
          ndone++;
          chk("done_busy", busy, 0);
        end
        if (bus.ss_query) k = K_Q;
        else if (bus.ss_read) k = K_RD;
        else if (bus.ss_write) k = K_WR;
        else if (bus.mem_we) k = K_MW;
        else k = K_MR;
        if (((bus.ss_query || bus.ss_read || bus.ss_write) &&
             bus.ss_ack) || (bus.mem_req && bus.mem_ack)) begin
          if (expq.size() == 0) begin
            chk("extra_txn", 64'(k), 64'hFF);
          end else begin
            t = expq.pop_front();
            chk("txn_kind", 64'(k), 64'(t.kind));
            if (k == t.kind) begin
              if (k <= K_WR)
                chk("ss_idx", bus.ss_idx, 64'(t.idx));
              if (k == K_RD || k == K_WR)
                chk("ss_addr", bus.ss_addr, 64'(t.addr));
              if (k == K_WR)
                chk("ss_wdata", bus.ss_wdata, t.data);
              if (k >= K_MW)
                chk("mem_addr", bus.mem_addr, 64'(t.addr));
              if (k == K_MW)
                chk("mem_wdata", bus.mem_wdata, t.data);
            end
          end
        end
      end
    end
  endtask

  task automatic run_op(input bit sv, input bit rs,
                        input logic [23:0] base, input int poke);
    int d0;
    bit fin;
    d0 = ndone;
    @(negedge clk);
    start_save = sv; start_restore = rs; base_addr = base;
    @(negedge clk);
    start_save = 0; start_restore = 0; base_addr = '0;
    #1;
    chk("start_busy", busy, 1);
    chk("start_query", bus.ss_query, 1);
    chk("start_err_clr", error, 0);
    fin = 1'b0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      @(negedge clk);
      start_save    = (k == poke);
      start_restore = (k == poke);
      base_addr     = (k == poke) ? 24'h200 : 24'h0;
      #1;
      if (!busy) fin = 1'b1;
    end
    start_save = 0; start_restore = 0;
    chk("finish", fin, 1);
    @(negedge clk);
    #2;
    chk("done_cnt", 64'(ndone - d0), exp_err ? 64'd0 : 64'd1);
    chk("error", error, exp_err);
    chk("queue_left", 64'(expq.size()), 0);
  endtask

  initial begin
    int w0;
    bit hit;
    reset = 1'b1;
    start_save = 0; start_restore = 0; base_addr = '0;
    present[0] = 1'b1; scnt[0] = 2;
    present[1] = 1'b0; scnt[1] = 0;
    for (int i = 0; i < NIDX; i++)
      for (int r = 0; r < 4; r++) begin
        sregs[i][r] = '0;
        swr[i][r]   = '0;
      end
    sregs[0][0] = 64'h11;
    sregs[0][1] = 64'h22;
    fork
      slave_resp();
      mem_resp();
      monitor();
    join_none

    #12;
    chk("rst_ctl", {busy, done, error}, 0);
    chk("rst_strobe", {bus.ss_query, bus.ss_read, bus.ss_write,
                       bus.mem_req, bus.mem_we}, 0);
    chk("rst_ss", {bus.ss_idx, bus.ss_addr}, 0);
    chk("rst_data", bus.ss_wdata | bus.mem_wdata, 0);
    chk("rst_maddr", bus.mem_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    // save, two indices, second absent
    model_save(24'h100);
    run_op(1, 0, 24'h100, -1);
    chk("img_100", mem[32'h100], 64'h0000_0000_0000_0002);
    chk("img_101", mem[32'h101], 64'h11);
    chk("img_102", mem[32'h102], 64'h22);
    chk("img_103", mem[32'h103], 64'h0100_0000_0000_0000);

    // restore of that image
    img[32'h100] = 64'h0000_0000_0000_0002;
    img[32'h101] = 64'h11;
    img[32'h102] = 64'h22;
    img[32'h103] = 64'h0100_0000_0000_0000;
    w0 = nwr;
    model_restore(24'h100);
    run_op(0, 1, 24'h100, -1);
    chk("rst_wr_n", 64'(nwr - w0), 2);
    chk("rst_wr0", swr[0][0], 64'h11);
    chk("rst_wr1", swr[0][1], 64'h22);

    // corrupted header: idx 5
    img[32'h100] = 64'h0500_0000_0000_0002;
    w0 = nwr;
    model_restore(24'h100);
    run_op(0, 1, 24'h100, -1);
    chk("bad_hdr_err", error, 1);
    chk("bad_hdr_busy", busy, 0);
    chk("bad_hdr_wr", 64'(nwr - w0), 0);

    // both starts together plus a start while busy
    model_save(24'h100);
    run_op(1, 1, 24'h100, 5);

    // pointer wrap
    model_save(24'hFFFFFF);
    run_op(1, 0, 24'hFFFFFF, -1);
    chk("wrap_hdr", mem[32'hFFFFFF], 64'h2);
    chk("wrap_d0", mem[32'h0], 64'h11);
    chk("wrap_d1", mem[32'h1], 64'h22);

    // async reset during MEM_WR, then a clean save
    model_save(24'h300);
    @(negedge clk);
    start_save = 1; base_addr = 24'h300;
    @(negedge clk);
    start_save = 0; base_addr = '0;
    hit = 1'b0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      @(negedge clk);
      #1;
      if (bus.mem_req && bus.mem_we && bus.mem_addr == 24'h301)
        hit = 1'b1;
    end
    chk("reach_memwr", hit, 1);
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("arst_ctl", {busy, done, error}, 0);
    chk("arst_strobe", {bus.ss_query, bus.ss_read, bus.ss_write,
                        bus.mem_req, bus.mem_we}, 0);
    chk("arst_maddr", bus.mem_addr, 0);
    chk("arst_mwdata", bus.mem_wdata, 0);
    chk("arst_ss", {bus.ss_idx, bus.ss_addr}, 0);
    @(negedge clk);
    reset = 1'b0;
    expq.delete();
    chk_en = 1'b1;
    model_save(24'h300);
    run_op(1, 0, 24'h300, -1);
    chk("after_rst_d1", mem[32'h302], 64'h22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ss_state_master.md
# ss_state_master

Save-state bus initiator: walks every save-state index, reads each slave's registers over the save-state bus and streams them to external memory (save), or streams memory back into the slaves (restore). Sits between the top-level save/restore controls and every chip model exposing a save-state slave (priority mixer, video chips, CPU glue). It is the only driver of the slave-side select, address, data and strobe signals.

## Interface
- `NUM_IDX`, 32: number of save-state indices scanned, 0..NUM_IDX-1.
- `ADDR_W`, 24: memory word-address width; one word is 64 bits.
- `TIMEOUT`, 255: cycles to wait for a slave ack before the index is treated as absent.

- `clk`  in  1  system clock.
- `reset`  in  1  reset; asynchronous and active-high.
- `start_save`  in  1  one-cycle pulse starting a save; ignored unless idle.
- `start_restore`  in  1  one-cycle pulse starting a restore; ignored unless idle. If both pulses arrive in the same cycle, save wins.
- `base_addr`  in  ADDR_W  first memory word; sampled on start.
- `busy`  out  1  high from the cycle after the start pulse until done/error.
- `done`  out  1  one-cycle pulse on successful completion.
- `error`  out  1  sticky; set on restore header mismatch; cleared by the next start.
- `ss_idx`  out  8  selected slave index.
- `ss_addr`  out  8  register address within the slave.
- `ss_wdata`  out  64  restore data to the slave.
- `ss_query`, `ss_read`, `ss_write`  out  1  mutually exclusive request strobes, held until ack.
- `ss_ack`  in  1  slave acknowledge (write_ack / read_response).
- `ss_rdata`  in  64  slave read data. During a query, bits [15:0] carry the register count.
- `mem_req`, `mem_we`  out  1  memory request and direction, held until `mem_ack`.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  64  save data.
- `mem_ack`  in  1  memory acknowledge; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  64  restore data.

## Operation
- States: IDLE, QUERY, HDR, SLV_RD, MEM_WR, MEM_RD, SLV_WR, NEXT, DONE.
- QUERY: drive `ss_query` with `ss_idx` = current index.
  - If `ss_ack` arrives, latch count = `ss_rdata[15:0]`.
  - If no ack arrives within TIMEOUT cycles, set count = 0 (slave absent).
- HDR:
  - Save: write the header word {idx[7:0], 40'b0, count[15:0]} to memory.
  - Restore: read the header word. If its idx field does not equal the current index, or its count does not equal the queried count, set `error`, go to DONE with no `done` pulse, and return to IDLE.
- Save per register: SLV_RD (`ss_read`, latch `ss_rdata` on ack), then MEM_WR (write the latched word). Restore per register: MEM_RD, then SLV_WR.
- `ss_addr` runs 0..count-1. The address is truncated to 8 bits; slaves report count ≤ 256.
- The memory pointer starts at `base_addr` and increments by 1 after every memory ack. It wraps modulo 2^ADDR_W with no error.
- NEXT: advance the index. After NUM_IDX-1, go to DONE.
- A count-0 index still writes (or checks) its header, then advances.
- DONE: pulse `done` for one cycle, then return to IDLE.
- Strobes never overlap; at most one of `ss_*` and `mem_req` is active in any cycle.

## Timing
- Reset values: state IDLE; all strobes 0; `busy`, `done`, `error` 0; `ss_idx`, `ss_addr`, `ss_wdata`, `mem_addr`, `mem_wdata` 0.
- Start pulse at cycle N: `busy` = 1 and `ss_query` = 1 at N+1.
- A request is deasserted in the cycle after its ack. The next request asserts one cycle later, so there is one idle gap cycle between transactions.
- An ack arriving in the first cycle of a request is valid.
- The timeout counter applies only to `ss_query`, `ss_read` and `ss_write`. Memory waits forever.
  - A read or write timeout after a successful query sets `error` and ends the operation.
- `busy` falls in the same cycle `done` pulses.
- An asserted `reset` mid-operation returns the block to IDLE immediately. Memory contents are undefined and no `done` pulse is issued.

## Structure
- Shared package `ss_pkg`:
  - state enum `ss_state_t`
  - header field positions `SS_HDR_IDX_LSB` = 56 and `SS_HDR_CNT_W` = 16
  - `SS_DATA_W` = 64
- One sub-module, `ss_timeout`: a loadable down-counter with an expire flag, shared by all slave waits.

## Test plan
- Save, NUM_IDX = 2. Idx0 count 2 with regs 0x11 and 0x22; idx1 absent. Memory from base 0x100 must be:
  - 0x100: header idx0, count 2
  - 0x101: 0x11
  - 0x102: 0x22
  - 0x103: header idx1, count 0
  - then `done`.
- Restore of that image: slave idx0 receives writes addr0 = 0x11 and addr1 = 0x22, then `done` with `error` = 0.
- Restore with the header at 0x100 corrupted to idx 5: `error` = 1, no slave writes occur, `busy` falls, no `done` pulse.
- `start_save` and `start_restore` in the same cycle: the save runs (`mem_we` = 1 on the first memory access). A start pulse while `busy` is ignored.
- `base_addr` = 0xFFFFFF with a 2-register slave: the data words land at 0x000000 and 0x000001.
- `reset` asserted during MEM_WR: all outputs return to their reset values asynchronously; a following `start_save` completes normally.
